// File: rtl/posterior_decision_unit_if.sv
// rtl/posterior_decision_unit_if.sv - host/array-side bundle for the posterior decision unit (optional PDU_EARLY_STOP_EN)
interface posterior_decision_unit_if #(
    parameter int Narray = 2,
    parameter int CNT_W  = 10,
    parameter int CLS_W  = Narray
) ();
    localparam int NCLASS = 2 ** Narray;

    logic              start;
    logic [CNT_W-1:0]  window_len;
    logic [NCLASS-1:0] bit_in;
    logic              bit_valid;
    logic [CLS_W-1:0]  rd_sel;
    logic              busy;
    logic              done;
    logic [CLS_W-1:0]  winner;
    logic [CNT_W-1:0]  winner_count;
    logic              tie;
    logic [CNT_W-1:0]  rd_count;
`ifdef PDU_EARLY_STOP_EN
    logic [CNT_W-1:0]  early_thresh;
    logic              early_stop;

    modport master (
        output start, window_len, bit_in, bit_valid, rd_sel, early_thresh,
        input  busy, done, winner, winner_count, tie, rd_count, early_stop
    );
    modport slave (
        input  start, window_len, bit_in, bit_valid, rd_sel, early_thresh,
        output busy, done, winner, winner_count, tie, rd_count, early_stop
    );
`else
    modport master (
        output start, window_len, bit_in, bit_valid, rd_sel,
        input  busy, done, winner, winner_count, tie, rd_count
    );
    modport slave (
        input  start, window_len, bit_in, bit_valid, rd_sel,
        output busy, done, winner, winner_count, tie, rd_count
    );
`endif
endinterface

// File: rtl/posterior_decision_unit.sv
// rtl/posterior_decision_unit.sv - per-class ones counting over a window, sequential argmax (optional PDU_EARLY_STOP_EN)
module posterior_decision_unit #(
    parameter int Narray = 2,
    parameter int CNT_W  = 10,
    parameter int CLS_W  = Narray
) (
    input  logic                         clk,
    input  logic                         rst,
    posterior_decision_unit_if.slave     bus
);
    localparam int NCLASS = 2 ** Narray;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        COMPARE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] smp_q, smp_d;
    logic [CNT_W-1:0] cnt_q [NCLASS];
    logic [CNT_W-1:0] cnt_d [NCLASS];
    logic [CLS_W-1:0] scan_q, scan_d;
    logic [CNT_W-1:0] best_q, best_d;
    logic [CLS_W-1:0] idx_q, idx_d;
    logic             stie_q, stie_d;
    logic [CLS_W-1:0] winner_q, winner_d;
    logic [CNT_W-1:0] wcnt_q, wcnt_d;
    logic             wtie_q, wtie_d;
`ifdef PDU_EARLY_STOP_EN
    logic [CNT_W-1:0] thresh_q, thresh_d;
    logic             early_run_q, early_run_d;
    logic             early_stop_q, early_stop_d;
    logic             hit;
`endif

    // Next-state, counter update and argmax scan
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        smp_d    = smp_q;
        cnt_d    = cnt_q;
        scan_d   = scan_q;
        best_d   = best_q;
        idx_d    = idx_q;
        stie_d   = stie_q;
        winner_d = winner_q;
        wcnt_d   = wcnt_q;
        wtie_d   = wtie_q;
`ifdef PDU_EARLY_STOP_EN
        thresh_d     = thresh_q;
        early_run_d  = early_run_q;
        early_stop_d = early_stop_q;
        hit          = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    len_d  = bus.window_len;
                    smp_d  = '0;
                    scan_d = '0;
                    for (int k = 0; k < NCLASS; k++) begin
                        cnt_d[k] = '0;
                    end
`ifdef PDU_EARLY_STOP_EN
                    thresh_d    = bus.early_thresh;
                    early_run_d = 1'b0;
`endif
                    // An empty window skips straight to the scan of all-zero counters
                    state_d = (bus.window_len == '0) ? COMPARE : ACCUM;
                end
            end
            ACCUM: begin
                if (bus.bit_valid) begin
                    for (int k = 0; k < NCLASS; k++) begin
                        cnt_d[k] = cnt_q[k] + CNT_W'(bus.bit_in[k]);
                    end
                    smp_d = smp_q + CNT_W'(1);
`ifdef PDU_EARLY_STOP_EN
                    if (thresh_q != '0) begin
                        for (int k = 0; k < NCLASS; k++) begin
                            if (cnt_d[k] == thresh_q) begin
                                hit = 1'b1;
                            end
                        end
                    end
`endif
                    if (smp_d == len_q) begin
                        state_d = COMPARE;
                        scan_d  = '0;
                    end
`ifdef PDU_EARLY_STOP_EN
                    // Only flagged as early when the window itself was not yet complete
                    else if (hit) begin
                        state_d     = COMPARE;
                        scan_d      = '0;
                        early_run_d = 1'b1;
                    end
`endif
                end
            end
            COMPARE: begin
                if (scan_q == '0) begin
                    best_d = cnt_q[0];
                    idx_d  = '0;
                    stie_d = 1'b0;
                end else if (cnt_q[scan_q] > best_q) begin
                    best_d = cnt_q[scan_q];
                    idx_d  = scan_q;
                    stie_d = 1'b0;
                end else if (cnt_q[scan_q] == best_q) begin
                    stie_d = 1'b1;
                end
                if (scan_q == CLS_W'(NCLASS - 1)) begin
                    // Result registers load here so they are valid during the done cycle
                    state_d  = DONE;
                    winner_d = idx_d;
                    wcnt_d   = best_d;
                    wtie_d   = stie_d;
`ifdef PDU_EARLY_STOP_EN
                    early_stop_d = early_run_q;
`endif
                end else begin
                    scan_d = scan_q + CLS_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            len_q    <= '0;
            smp_q    <= '0;
            for (int k = 0; k < NCLASS; k++) begin
                cnt_q[k] <= '0;
            end
            scan_q   <= '0;
            best_q   <= '0;
            idx_q    <= '0;
            stie_q   <= 1'b0;
            winner_q <= '0;
            wcnt_q   <= '0;
            wtie_q   <= 1'b0;
`ifdef PDU_EARLY_STOP_EN
            thresh_q     <= '0;
            early_run_q  <= 1'b0;
            early_stop_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            smp_q    <= smp_d;
            for (int k = 0; k < NCLASS; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
            scan_q   <= scan_d;
            best_q   <= best_d;
            idx_q    <= idx_d;
            stie_q   <= stie_d;
            winner_q <= winner_d;
            wcnt_q   <= wcnt_d;
            wtie_q   <= wtie_d;
`ifdef PDU_EARLY_STOP_EN
            thresh_q     <= thresh_d;
            early_run_q  <= early_run_d;
            early_stop_q <= early_stop_d;
`endif
        end
    end

    assign bus.busy         = (state_q == ACCUM) || (state_q == COMPARE);
    assign bus.done         = (state_q == DONE);
    assign bus.winner       = winner_q;
    assign bus.winner_count = wcnt_q;
    assign bus.tie          = wtie_q;
    assign bus.rd_count     = cnt_q[bus.rd_sel];
`ifdef PDU_EARLY_STOP_EN
    assign bus.early_stop   = early_stop_q;
`endif

endmodule

// File: tb/tb_posterior_decision_unit.sv
// tb/tb_posterior_decision_unit.sv - randomized self-checking bench for posterior_decision_unit
module tb_posterior_decision_unit;
    localparam int NARRAY = 2;
    localparam int CNT_W  = 10;
    localparam int NCLASS = 4;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    posterior_decision_unit_if #(.Narray(NARRAY), .CNT_W(CNT_W), .CLS_W(NARRAY)) bus ();

    posterior_decision_unit #(.Narray(NARRAY), .CNT_W(CNT_W), .CLS_W(NARRAY)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] table_bits(input int s);
        case (s)
            0:       return 4'b0111;
            1:       return 4'b1111;
            2, 3, 4: return 4'b1010;
            default: return 4'b1000;
        endcase
    endfunction

    task automatic check_cleared(input string tag);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_done"}, bus.done, 0);
        check({tag, "_winner"}, bus.winner, 0);
        check({tag, "_wcount"}, bus.winner_count, 0);
        check({tag, "_tie"}, bus.tie, 0);
`ifdef PDU_EARLY_STOP_EN
        check({tag, "_early"}, bus.early_stop, 0);
`endif
        for (int k = 0; k < NCLASS; k++) begin
            bus.rd_sel = 2'(k);
            #1;
            check({tag, "_rd_count"}, bus.rd_count, 0);
        end
    endtask

    // mode 0: random valid/bits, 1: constant pattern every cycle, 2: pattern on odd cycles, 3: tie table
    task automatic run(input int mode, input int len, input logic [3:0] pat,
                       input bit start_in_done, input int thr);
        int         cnt [NCLASS];
        int         nval, c_last, exp_done, got_done, mx, win, nmax;
        bit         early;
        logic       v;
        logic [3:0] b;
        nval = 0; early = 0; got_done = -1; exp_done = -1;
        c_last = (len == 0) ? 0 : -1;
        for (int k = 0; k < NCLASS; k++) cnt[k] = 0;
        for (int c = 0; c < 4000 && got_done < 0; c++) begin
            @(posedge clk); #1;
            case (mode)
                1:       begin v = 1'b1; b = pat; end
                2:       begin v = (c % 2 == 1); b = v ? pat : 4'($urandom); end
                3:       begin v = 1'b1; b = table_bits(nval); end
                default: begin v = ($urandom_range(0, 3) != 0); b = 4'($urandom); end
            endcase
            if (c == 0) bus.start = 1'b1;
            else if (exp_done >= 0 && c >= exp_done) bus.start = (c == exp_done) ? start_in_done : 1'b0;
            else bus.start = ($urandom_range(0, 3) == 0);
            bus.window_len = (c == 0) ? CNT_W'(len) : CNT_W'($urandom);
`ifdef PDU_EARLY_STOP_EN
            bus.early_thresh = (c == 0) ? CNT_W'(thr) : CNT_W'($urandom);
`endif
            bus.bit_valid = v;
            bus.bit_in    = b;
            if (c >= 1 && c_last < 0 && v) begin
                nval++;
                for (int k = 0; k < NCLASS; k++) cnt[k] += int'(b[k]);
                if (nval == len) c_last = c;
`ifdef PDU_EARLY_STOP_EN
                else if (thr != 0) begin
                    for (int k = 0; k < NCLASS; k++) if (cnt[k] == thr) early = 1;
                    if (early) c_last = c;
                end
`endif
            end
            if (c_last >= 0) exp_done = c_last + NCLASS + 1;
            @(negedge clk);
            if (c >= 1) check("busy", bus.busy, (exp_done < 0 || c < exp_done));
            if (bus.done) got_done = c;
        end
        check("done_cycle", got_done, exp_done);
        mx = -1; win = 0; nmax = 0;
        for (int k = 0; k < NCLASS; k++) if (cnt[k] > mx) begin mx = cnt[k]; win = k; end
        for (int k = 0; k < NCLASS; k++) if (cnt[k] == mx) nmax++;
        check("winner", bus.winner, win);
        check("winner_count", bus.winner_count, mx);
        check("tie", bus.tie, (nmax > 1));
`ifdef PDU_EARLY_STOP_EN
        check("early_stop", bus.early_stop, early);
`endif
        for (int k = 0; k < NCLASS; k++) begin
            bus.rd_sel = 2'(k);
            #1;
            check("rd_count", bus.rd_count, cnt[k]);
        end
        @(posedge clk); #1;
        bus.start = 1'b0; bus.bit_valid = 1'b0;
        @(negedge clk);
        check("idle_after_done_busy", bus.busy, 0);
        check("idle_after_done_done", bus.done, 0);
        check("hold_winner", bus.winner, win);
    endtask

    initial begin
        int seen_done;
        rst = 1'b1;
        bus.start = 1'b0; bus.window_len = '0; bus.bit_in = '0; bus.bit_valid = 1'b0; bus.rd_sel = '0;
`ifdef PDU_EARLY_STOP_EN
        bus.early_thresh = '0;
`endif
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_cleared("reset");

        run(1, 8, 4'b0100, 1'b1, 0);
        run(2, 4, 4'b1111, 1'b0, 0);
        run(3, 6, 4'b0000, 1'b1, 0);
        run(1, 0, 4'b1111, 1'b0, 0);

        // Reset in the middle of accumulation must abort without a done pulse
        @(posedge clk); #1;
        bus.start = 1'b1; bus.window_len = 10'd50; bus.bit_valid = 1'b1; bus.bit_in = 4'b1111;
        @(posedge clk); #1 bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_cleared("midreset");
        seen_done = 0;
        repeat (60) begin
            @(negedge clk);
            if (bus.done) seen_done++;
        end
        check("midreset_no_done", seen_done, 0);
        bus.bit_valid = 1'b0;

`ifdef PDU_EARLY_STOP_EN
        run(1, 100, 4'b0010, 1'b0, 3);
`endif
        run(1, 1023, 4'b1011, 1'b0, 0);
        for (int i = 0; i < 20; i++) begin
            run(0, $urandom_range(0, 40), 4'b0000, 1'($urandom),
                ($urandom_range(0, 1) == 1) ? $urandom_range(1, 10) : 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/posterior_decision_unit.md
Name: posterior_decision_unit

Overview:
- Sits directly downstream of the likelihood array top level, in stochastic mode (stoch_log = 0).
- Consumes the per-row bit_out streams. Each row is one class, and each cycle's bits are that class's stochastic posterior bit (AND of likelihood bits).
- Counts the ones per class over a programmable window, then finds the argmax sequentially.
- Reports the winning class, its count and a tie flag to the host with a start/done handshake.

Parameters:
- Narray, 2, array address size; number of classes NCLASS = 2**Narray.
- CNT_W, 10, width of the window length and of each class counter.
- CLS_W, Narray, width of the class index.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  begin a new decision when idle (ignored while busy)
- window_len  input  CNT_W  number of valid samples to accumulate; sampled on start
- bit_in  input  NCLASS  stochastic posterior bits, one per class (bit_out of array)
- bit_valid  input  1  bit_in holds a valid sample this cycle
- rd_sel  input  CLS_W  class whose counter is shown on rd_count
- busy  output  1  high from accepted start until done
- done  output  1  one-cycle pulse when result is valid
- winner  output  CLS_W  argmax class index, held until next start
- winner_count  output  CNT_W  count of winning class
- tie  output  1  another class equals the max count
- rd_count  output  CNT_W  combinational view of counter[rd_sel]

Behaviour:
- Reset (rst = 1 at a clock edge):
  - state = IDLE.
  - All counters, sample counter, winner, winner_count, tie = 0.
  - busy = 0, done = 0.
  - Reset mid-operation aborts with no done pulse.
- IDLE:
  - start = 1 -> latch window_len into len_q, clear all counters and the sample counter, busy = 1, go to ACCUM.
  - If window_len = 0, go directly to COMPARE with all counters 0.
- ACCUM:
  - Each cycle with bit_valid = 1: counter[k] += bit_in[k] for every k, and sample counter += 1.
  - Cycles with bit_valid = 0 change nothing.
  - When the sample counter reaches len_q (the update on the len_q-th valid sample is included), go to COMPARE.
  - Counters cannot overflow, since window_len ≤ 2**CNT_W − 1.
  - bit_in / bit_valid are ignored outside ACCUM.
- COMPARE: sequential scan, one class per cycle, NCLASS cycles.
  - Cycle 0: best = counter[0], idx = 0, tie = 0.
  - Each following cycle i:
    - counter[i] > best -> best = counter[i], idx = i, tie = 0.
    - counter[i] == best -> tie = 1.
  - Ties therefore resolve to the lowest index.
  - After class NCLASS−1, go to DONE.
- DONE:
  - winner = idx, winner_count = best, tie updated, done = 1 for exactly this cycle.
  - busy = 0 in the same cycle. Next state is IDLE.
- Latency: start accepted at cycle 0; done asserted at cycle (cycles to collect window_len valid samples) + NCLASS + 1.
- start asserted while busy: ignored, with no effect on the run in progress.
- start in the same cycle as done: ignored. A new start is accepted from the following cycle.
- Outputs winner, winner_count and tie hold their values between runs. They are cleared only by rst, not by start.
- rd_count is valid at any time. Counters hold their values after DONE until the next start.

Optional Feature:
- Macro PDU_EARLY_STOP_EN.
- Defined:
  - Adds input early_thresh [CNT_W-1:0], sampled on start.
  - In ACCUM, if any counter equals early_thresh after an update (and early_thresh ≠ 0), go to COMPARE immediately, even if fewer than len_q samples were seen.
  - Adds output early_stop (1 bit), set at DONE if the run ended early, else 0. Reset value 0.
- Not defined: no extra ports; the window always runs to len_q samples.

Test Plan:
- Reset then idle -> after rst: busy = 0, done = 0, winner = 0, winner_count = 0, tie = 0, rd_count = 0 for every rd_sel.
- window_len = 8, bit_valid = 1 for 8 cycles, bit_in = 4'b0100 every cycle -> done pulses at cycle 8 + 4 + 1 = 13; winner = 2, winner_count = 8, tie = 0; rd_count = 0/0/8/0 for classes 0/1/2/3.
- window_len = 4, bit_valid toggling 1,0,1,0…, bit_in = 4'b1111 on valid cycles -> counting pauses on invalid cycles; all counters = 4; winner = 0, tie = 1.
- Tie resolves to lowest index: 6 samples, class 1 and class 3 each get 5 ones, others 2 -> winner = 1, winner_count = 5, tie = 1.
- start pulsed during ACCUM and in the done cycle -> no restart and no counter clear. rst asserted mid-ACCUM -> no done pulse, all outputs return to 0.
- With PDU_EARLY_STOP_EN: window_len = 100, early_thresh = 3, bit_in = 4'b0010 every cycle -> class 1 reaches 3 after 3 samples; done at cycle 3 + 4 + 1 = 8; winner = 1, winner_count = 3, early_stop = 1.
